dbus_slave_decoder: RTL and testbench
=====================================

Name: dbus_slave_decoder

Overview:
- Sits directly downstream of the data-bus arbiter's slave port and fans that single bus out to four memory-mapped slaves: RAM, peripheral block, VGA and SD controller.
- Decodes each request address against four base/mask windows and forwards the strobe to exactly one slave.
- Registers the request for the whole transaction and routes that slave's nak/data back upstream.
- A watchdog aborts any slave that stalls too long; unmapped accesses complete immediately and are flagged as errors.

Parameters:
- BASE0, 32'h0000_0000, window 0 base (RAM)
- MASK0, 32'hF000_0000, window 0 compare mask
- BASE1, 32'hBFC0_0000, window 1 base (peripherals)
- MASK1, 32'hFFFF_0000, window 1 compare mask
- BASE2, 32'hBC00_0000, window 2 base (VGA)
- MASK2, 32'hFF00_0000, window 2 compare mask
- BASE3, 32'hBFD0_0000, window 3 base (SD)
- MASK3, 32'hFFFF_0000, window 3 compare mask
- TIMEOUT, 255, max stall cycles before abort (1..65535)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- addrM  in  32  request address from arbiter
- doutM  in  32  write data from arbiter
- stbM  in  1  request strobe, one cycle per request
- weM  in  1  write enable
- dmM  in  4  byte mask
- dinM  out  32  read data to arbiter
- nakM  out  1  wait to arbiter
- addrS  out  32  address broadcast to all slaves
- dinS  out  32  write data broadcast
- weS  out  1  write enable broadcast
- dmS  out  4  byte mask broadcast
- stbS  out  4  one-hot strobe per slave
- abortS  out  4  one-cycle abort pulse per slave on timeout
- doutS  in  128  read data, slave i in bits [32i+31:32i]
- nakS  in  4  per-slave wait
- err  out  1  sticky error flag
- errAddr  out  32  address of first error
- errClr  in  1  clears err and errAddr

Behaviour:
- Hit i = ((addrM ^ BASEi) & MASKi) == 0.
- Overlapping hits: lowest index wins. No hit = unmapped.
- State machine: IDLE, BUSY.
- Reset (rst low, async): state IDLE, sel=0, request register 0, counter 0, err=0, errAddr=0.
- Outputs in IDLE with stbM=0: stbS=0, abortS=0, nakM=0, dinM=0.
- IDLE, stbM=1, mapped to slave i:
  - Same cycle: stbS[i]=1; addrS/dinS/weS/dmS driven combinationally from M inputs.
  - Same cycle: nakM=nakS[i], dinM=doutS[i].
  - Edge: request fields latched, sel<=i.
  - If nakS[i]=1: go to BUSY with counter=1. Else stay IDLE (zero-wait completion).
- BUSY:
  - stbS=0; broadcast outputs driven from the request register.
  - nakM=nakS[sel], dinM=doutS[sel].
  - nakS[sel]=0: completion this cycle, next state IDLE.
  - Otherwise counter increments.
  - When counter==TIMEOUT and nakS[sel] still 1: that cycle drives nakM=0, dinM=0, abortS[sel]=1; next state IDLE; err is set.
- IDLE, stbM=1, unmapped: no stbS; nakM=0, dinM=32'h0 same cycle; err set.
- err/errAddr:
  - err set on the edge after the event.
  - errAddr loads the request address only when err was 0, so it holds the first error.
  - errClr=1 clears both.
  - A new error in the same cycle as errClr: set wins, errAddr loads the new address.
- stbM=1 while BUSY is an upstream protocol violation. It is not forwarded, does not affect the current transaction, and sets err with that address.
- nakS of non-selected slaves is ignored at all times. A slave deasserting nak after its abort is ignored.
- Counter is 16 bits and saturates; it never wraps.
- Reset asserted in BUSY: immediate IDLE, no abort pulse, nakM=0.
- Latency: zero added cycles. Decoder adds no wait states. nakM tracks the selected slave's nakS combinationally.

Test Plan:
- Read, zero-wait: stbM with addrM=32'h0000_0100, nakS=0, doutS[31:0]=32'h1234_5678 -> same cycle stbS=4'b0001, nakM=0, dinM=32'h1234_5678; state stays IDLE.
- Write, waited: stbM, weM=1, addrM=32'hBFC0_0010, dmM=4'b0011; slave 1 holds nak for 3 cycles -> stbS=4'b0010 for one cycle only; nakM high 3 cycles; addrS/dmS stable throughout; completion on cycle 4.
- Timeout: TIMEOUT=8; slave 2 never drops nak -> on the 8th BUSY cycle nakM=0, dinM=0, abortS=4'b0100 for one cycle; err=1, errAddr=request address.
- Unmapped then clear: addrM=32'h7000_0000 -> no stbS, nakM=0, dinM=0, err=1, errAddr=32'h7000_0000; a second unmapped access leaves errAddr unchanged; errClr -> err=0, errAddr=0.
- Overlap/priority: BASE1 window covering an address also in window 3 -> stbS=4'b0010 only.
- Async reset mid-BUSY: drop rst with slave 0 stalled -> nakM=0 and stbS=0 immediately; after release the next request decodes normally.

Source files
------------

// File: rtl/dbus_slave_decoder.sv
// Fans the arbiter's data-bus slave port out to RAM/periph/VGA/SD windows, holds the request
// for the whole transaction, aborts stalled slaves after TIMEOUT cycles and latches the first error.
module dbus_slave_decoder #(
  parameter logic [31:0] BASE0   = 32'h0000_0000,
  parameter logic [31:0] MASK0   = 32'hF000_0000,
  parameter logic [31:0] BASE1   = 32'hBFC0_0000,
  parameter logic [31:0] MASK1   = 32'hFFFF_0000,
  parameter logic [31:0] BASE2   = 32'hBC00_0000,
  parameter logic [31:0] MASK2   = 32'hFF00_0000,
  parameter logic [31:0] BASE3   = 32'hBFD0_0000,
  parameter logic [31:0] MASK3   = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addrM,
  input  logic [31:0]  doutM,
  input  logic         stbM,
  input  logic         weM,
  input  logic [3:0]   dmM,
  output logic [31:0]  dinM,
  output logic         nakM,
  output logic [31:0]  addrS,
  output logic [31:0]  dinS,
  output logic         weS,
  output logic [3:0]   dmS,
  output logic [3:0]   stbS,
  output logic [3:0]   abortS,
  input  logic [127:0] doutS,
  input  logic [3:0]   nakS,
  output logic         err,
  output logic [31:0]  errAddr,
  input  logic         errClr
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        we_q, we_d;
  logic [3:0]  dm_q, dm_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [3:0]  hit;
  logic        mapped;
  logic [1:0]  dec_idx;
  logic        err_evt;
  logic [31:0] evt_addr;

  always_comb begin
    hit[0] = ((addrM ^ BASE0) & MASK0) == 32'h0;
    hit[1] = ((addrM ^ BASE1) & MASK1) == 32'h0;
    hit[2] = ((addrM ^ BASE2) & MASK2) == 32'h0;
    hit[3] = ((addrM ^ BASE3) & MASK3) == 32'h0;
    mapped = |hit;
    // Lowest window index wins when windows overlap.
    if (hit[0])      dec_idx = 2'd0;
    else if (hit[1]) dec_idx = 2'd1;
    else if (hit[2]) dec_idx = 2'd2;
    else             dec_idx = 2'd3;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    we_d     = we_q;
    dm_d     = dm_q;
    cnt_d    = cnt_q;
    stbS     = 4'b0000;
    abortS   = 4'b0000;
    nakM     = 1'b0;
    dinM     = 32'h0;
    addrS    = addrM;
    dinS     = doutM;
    weS      = weM;
    dmS      = dmM;
    err_evt  = 1'b0;
    evt_addr = addrM;

    case (state_q)
      IDLE: begin
        if (stbM) begin
          if (mapped) begin
            stbS   = 4'b0001 << dec_idx;
            nakM   = nakS[dec_idx];
            dinM   = doutS[{dec_idx, 5'b0} +: 32];
            sel_d  = dec_idx;
            addr_d = addrM;
            wdat_d = doutM;
            we_d   = weM;
            dm_d   = dmM;
            if (nakS[dec_idx]) begin
              state_d = BUSY;
              cnt_d   = 16'd1;
            end
          end else begin
            err_evt = 1'b1;
          end
        end
      end

      BUSY: begin
        addrS = addr_q;
        dinS  = wdat_q;
        weS   = we_q;
        dmS   = dm_q;
        // A strobe here is an upstream protocol violation: flagged, never forwarded.
        if (stbM) err_evt = 1'b1;
        if (!nakS[sel_q]) begin
          dinM    = doutS[{sel_q, 5'b0} +: 32];
          state_d = IDLE;
        end else if (cnt_q == TO_CNT) begin
          abortS   = 4'b0001 << sel_q;
          state_d  = IDLE;
          err_evt  = 1'b1;
          evt_addr = addr_q;
        end else begin
          nakM  = 1'b1;
          dinM  = doutS[{sel_q, 5'b0} +: 32];
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Clear first so a coincident new error wins and records its own address.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (errClr) begin
      err_d      = 1'b0;
      err_addr_d = 32'h0;
    end
    if (err_evt) begin
      err_d = 1'b1;
      if (!err_q || errClr) err_addr_d = evt_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      addr_q     <= 32'h0;
      wdat_q     <= 32'h0;
      we_q       <= 1'b0;
      dm_q       <= 4'h0;
      cnt_q      <= 16'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      we_q       <= we_d;
      dm_q       <= dm_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err     = err_q;
  assign errAddr = err_addr_q;

endmodule

// File: tb/tb_dbus_slave_decoder.sv
// Bench for dbus_slave_decoder: directed and random transactions checked against a
// transaction-level model of window decode, stall/timeout timing and first-error capture.
module tb_dbus_slave_decoder;

  localparam int TO = 8;
  localparam logic [31:0] BASES [4] = '{32'h0000_0000, 32'hBFC0_0000, 32'hBC00_0000, 32'hBFD0_0000};
  localparam logic [31:0] MASKS [4] = '{32'hF000_0000, 32'hFFFF_0000, 32'hFF00_0000, 32'hFFE0_0000};

  logic         clk, rst;
  logic [31:0]  addrM, doutM, dinM, addrS, dinS, errAddr;
  logic         stbM, weM, nakM, weS, err, errClr;
  logic [3:0]   dmM, dmS, stbS, abortS, nakS;
  logic [127:0] doutS;

  int          total = 0;
  int          bad   = 0;
  logic        err_m = 1'b0;
  logic [31:0] ea_m  = 32'h0;

  dbus_slave_decoder #(.MASK3(32'hFFE0_0000), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .addrM(addrM), .doutM(doutM), .stbM(stbM), .weM(weM), .dmM(dmM),
    .dinM(dinM), .nakM(nakM), .addrS(addrS), .dinS(dinS), .weS(weS), .dmS(dmS), .stbS(stbS),
    .abortS(abortS), .doutS(doutS), .nakS(nakS), .err(err), .errAddr(errAddr), .errClr(errClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (((a ^ BASES[i]) & MASKS[i]) == 32'h0) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic note_err(input logic [31:0] a);
    if (!err_m) ea_m = a;
    err_m = 1'b1;
  endtask

  // One upstream request; slave holds nak for the first w cycles (cycle 0 = strobe cycle).
  // vk>0 injects an illegal strobe to address va on BUSY cycle vk.
  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] dm,
                     input logic [31:0] wd, input int w, input int vk, input logic [31:0] va,
                     input logic clr, input logic [31:0] rd);
    int idx;
    logic [127:0] ds;
    logic [3:0] nk;
    logic ab;
    idx = decode(a);
    @(negedge clk);
    addrM = a; doutM = wd; weM = we; dmM = dm; stbM = 1'b1; errClr = clr;
    ds = {$urandom, $urandom, $urandom, $urandom};
    nk = 4'($urandom);
    if (idx >= 0) begin
      nk[idx] = (w > 0);
      if (rd != 32'h0) ds[idx*32 +: 32] = rd;
    end
    doutS = ds; nakS = nk;
    if (clr) begin err_m = 1'b0; ea_m = 32'h0; end
    #1;
    if (idx < 0) begin
      chk("unm_stbS", 32'(stbS), 32'h0);
      chk("unm_nakM", 32'(nakM), 32'h0);
      chk("unm_dinM", dinM, 32'h0);
      note_err(a);
    end else begin
      chk("stb_stbS", 32'(stbS), 32'(4'b0001 << idx));
      chk("stb_nakM", 32'(nakM), 32'(w > 0));
      chk("stb_dinM", dinM, ds[idx*32 +: 32]);
      chk("stb_addrS", addrS, a);
      chk("stb_dinS", dinS, wd);
      chk("stb_weS", 32'(weS), 32'(we));
      chk("stb_dmS", 32'(dmS), 32'(dm));
    end
    if (idx >= 0 && w > 0) begin
      for (int k = 1; k < 100; k++) begin
        @(negedge clk);
        errClr = 1'b0;
        stbM   = (k == vk);
        addrM  = (k == vk) ? va : $urandom;
        doutM  = $urandom; weM = 1'($urandom); dmM = 4'($urandom);
        ds = {$urandom, $urandom, $urandom, $urandom};
        nk = 4'($urandom);
        nk[idx] = (k < w);
        doutS = ds; nakS = nk;
        #1;
        ab = (k == TO) && (k < w);
        chk("busy_stbS", 32'(stbS), 32'h0);
        chk("busy_addrS", addrS, a);
        chk("busy_dinS", dinS, wd);
        chk("busy_weS", 32'(weS), 32'(we));
        chk("busy_dmS", 32'(dmS), 32'(dm));
        chk("busy_nakM", 32'(nakM), 32'((k < w) && !ab));
        chk("busy_dinM", dinM, ab ? 32'h0 : ds[idx*32 +: 32]);
        chk("busy_abortS", 32'(abortS), ab ? 32'(4'b0001 << idx) : 32'h0);
        if (ab) note_err(a);
        if (k == vk) note_err(va);
        if (!(k < w) || ab) break;
      end
    end
    @(negedge clk);
    stbM = 1'b0; errClr = 1'b0; nakS = 4'h0; doutS = '0;
    #1;
    chk("idle_stbS", 32'(stbS), 32'h0);
    chk("idle_nakM", 32'(nakM), 32'h0);
    chk("idle_abortS", 32'(abortS), 32'h0);
    chk("idle_dinM", dinM, 32'h0);
    chk("err", 32'(err), 32'(err_m));
    chk("errAddr", errAddr, ea_m);
  endtask

  task automatic clear_err();
    @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    err_m = 1'b0; ea_m = 32'h0;
    #1;
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_errAddr", errAddr, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    rst = 1'b0; addrM = 32'h0; doutM = 32'h0; stbM = 1'b0; weM = 1'b0; dmM = 4'h0;
    doutS = '0; nakS = 4'h0; errClr = 1'b0;
    #1;
    chk("rst_stbS", 32'(stbS), 32'h0);
    chk("rst_abortS", 32'(abortS), 32'h0);
    chk("rst_nakM", 32'(nakM), 32'h0);
    chk("rst_dinM", dinM, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_errAddr", errAddr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait read, waited write, timeout on VGA.
    txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 32'h1234_5678);
    txn(32'hBFC0_0010, 1'b1, 4'b0011, 32'hCAFE_F00D, 3, 0, 32'h0, 1'b0, 32'h0);
    txn(32'hBC00_0040, 1'b0, 4'hF, 32'h0, 20, 0, 32'h0, 1'b0, 32'h0);
    txn(32'hBC00_0080, 1'b0, 4'hF, 32'h0, TO, 0, 32'h0, 1'b0, 32'h0);
    clear_err();

    // Unmapped, second unmapped keeps first address, then clear.
    txn(32'h7000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0);
    txn(32'h7100_0004, 1'b1, 4'h1, 32'h5, 0, 0, 32'h0, 1'b0, 32'h0);
    clear_err();

    // Window 1 shadows part of window 3; uncovered part reaches SD.
    txn(32'hBFC0_1234, 1'b0, 4'hF, 32'h0, 1, 0, 32'h0, 1'b0, 32'h0);
    txn(32'hBFD0_0020, 1'b1, 4'hC, 32'h77, 2, 0, 32'h0, 1'b0, 32'h0);

    // Illegal strobe while BUSY, then clear coinciding with a new error.
    txn(32'h0000_0200, 1'b0, 4'hF, 32'h0, 5, 2, 32'hBFC0_0000, 1'b0, 32'h0);
    txn(32'h9000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0);
    clear_err();

    // Async reset while slave 0 is stalling.
    @(negedge clk);
    addrM = 32'h0000_0040; stbM = 1'b1; nakS = 4'b0001; doutS = {4{32'hA5A5_5A5A}};
    #1;
    chk("rb_stbS", 32'(stbS), 32'h1);
    chk("rb_nakM", 32'(nakM), 32'h1);
    @(negedge clk);
    stbM = 1'b0;
    #1;
    chk("rb_busy_nakM", 32'(nakM), 32'h1);
    #2;
    rst = 1'b0;
    err_m = 1'b0; ea_m = 32'h0;
    #1;
    chk("rb_rst_nakM", 32'(nakM), 32'h0);
    chk("rb_rst_stbS", 32'(stbS), 32'h0);
    chk("rb_rst_abortS", 32'(abortS), 32'h0);
    chk("rb_rst_dinM", dinM, 32'h0);
    @(negedge clk);
    nakS = 4'h0;
    rst = 1'b1;
    txn(32'h0000_0300, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0);
    txn(32'hBC12_3450, 1'b1, 4'h3, 32'h99, 2, 0, 32'h0, 1'b0, 32'h0);

    // Random traffic across all windows and unmapped space.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 4);
      if (sel < 4) a = BASES[sel] | (~MASKS[sel] & $urandom);
      else         a = 32'h7000_0000 | ($urandom & 32'h0FFF_FFFF);
      txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 12), 0, 32'h0,
          ($urandom_range(0, 7) == 0), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
